// File: rtl/matrix_transpose_pkg.sv
// matrix_transpose_pkg: shared line width, element-count helper and core state encoding
package matrix_transpose_pkg;
  localparam int LINE_WIDTH = 512;
  typedef enum logic {FILL, DRAIN} state_t;
  function automatic int n_of(input int dw);
    return LINE_WIDTH / dw;
  endfunction
endpackage

// File: rtl/afu_sync_fifo.sv
// afu_sync_fifo: synchronous FIFO with occupancy flags and registered read data
module afu_sync_fifo #(
  parameter int WIDTH = 512,
  parameter int DEPTH_BITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      din,
  input  logic                  we,
  input  logic                  re,
  output logic [WIDTH-1:0]      dout,
  output logic                  full,
  output logic                  almost_full,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [DEPTH_BITS:0]   count
);
  localparam int DEPTH = 1 << DEPTH_BITS;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_BITS-1:0] wptr, rptr;
  logic wr, rd;
  always_comb begin
    full = count == (DEPTH_BITS+1)'(DEPTH);
    almost_full = count >= (DEPTH_BITS+1)'(DEPTH-1);
    empty = count == '0;
    almost_empty = count <= (DEPTH_BITS+1)'(1);
    wr = we && !full;
    rd = re && !empty;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      dout <= '0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) begin
        rptr <= rptr + 1'b1;
        dout <= mem[rptr];
      end
      if (wr && !rd) count <= count + 1'b1;
      else if (rd && !wr) count <= count - 1'b1;
    end
  always_ff @(posedge clk)
    if (wr) mem[wptr] <= din;
endmodule

// File: rtl/matrix_transpose_afu.sv
// matrix_transpose_afu: buffers N rows of an NxN matrix and streams out its N columns
module matrix_transpose_afu
  import matrix_transpose_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BUFF_DEPTH_BITS = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [LINE_WIDTH-1:0]       input_fifo_din,
  input  logic                        input_fifo_we,
  output logic                        input_fifo_full,
  output logic                        input_fifo_almost_full,
  output logic [BUFF_DEPTH_BITS:0]    input_fifo_count,
  output logic [LINE_WIDTH-1:0]       output_fifo_dout,
  input  logic                        output_fifo_re,
  output logic                        output_fifo_empty,
  output logic                        output_fifo_almost_empty,
  input  logic [31:0]                 ctx_length
);
  localparam int N = n_of(DATA_WIDTH);
  localparam int CW = N > 1 ? $clog2(N) : 1;
  state_t state, state_d;
  logic [CW-1:0] row_cnt, col_cnt, pend_row;
  logic [31:0] line_cnt;
  logic [LINE_WIDTH-1:0] buf_q [N];
  logic [LINE_WIDTH-1:0] in_dout, col_line;
  logic in_empty, in_re, out_full, out_we, pend, last_row, flush;
  afu_sync_fifo #(.WIDTH(LINE_WIDTH), .DEPTH_BITS(BUFF_DEPTH_BITS)) u_in (
    .clk(clk), .reset(reset), .din(input_fifo_din), .we(input_fifo_we), .re(in_re),
    .dout(in_dout), .full(input_fifo_full), .almost_full(input_fifo_almost_full),
    .empty(in_empty), .almost_empty(), .count(input_fifo_count)
  );
  afu_sync_fifo #(.WIDTH(LINE_WIDTH), .DEPTH_BITS(BUFF_DEPTH_BITS)) u_out (
    .clk(clk), .reset(reset), .din(col_line), .we(out_we), .re(output_fifo_re),
    .dout(output_fifo_dout), .full(out_full), .almost_full(),
    .empty(output_fifo_empty), .almost_empty(output_fifo_almost_empty), .count()
  );
  always_comb begin
    in_re = state == FILL && !in_empty;
    out_we = state == DRAIN && !out_full;
    last_row = in_re && row_cnt == CW'(N-1);
    flush = in_re && ctx_length != '0 && line_cnt + 32'd1 == ctx_length;
    state_d = state == FILL ? (last_row || flush ? DRAIN : FILL)
                            : (out_we && col_cnt == CW'(N-1) ? FILL : DRAIN);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= FILL;
      row_cnt <= '0;
      col_cnt <= '0;
      line_cnt <= '0;
      pend <= 1'b0;
      pend_row <= '0;
    end else begin
      state <= state_d;
      pend <= in_re;
      pend_row <= row_cnt;
      if (in_re) begin
        line_cnt <= line_cnt + 32'd1;
        row_cnt <= last_row || flush ? '0 : row_cnt + 1'b1;
      end
      if (out_we) col_cnt <= col_cnt == CW'(N-1) ? '0 : col_cnt + 1'b1;
    end
  // popped rows land one cycle late (registered FIFO read); rows past a flushed job end are zeroed
  always_ff @(posedge clk) begin
    if (pend) buf_q[pend_row] <= in_dout;
    if (flush)
      for (int r = 0; r < N; r++)
        if (CW'(r) > row_cnt) buf_q[r] <= '0;
  end
  // the row still in flight from the input FIFO is bypassed into the first column read
  for (genvar r = 0; r < N; r++) begin : g_col
    assign col_line[r*DATA_WIDTH +: DATA_WIDTH] = pend && pend_row == CW'(r)
      ? in_dout[col_cnt*DATA_WIDTH +: DATA_WIDTH] : buf_q[r][col_cnt*DATA_WIDTH +: DATA_WIDTH];
  end
endmodule

// File: tb/tb_matrix_transpose_afu.sv
// tb_matrix_transpose_afu: randomized and table-driven checks against a queue-based transpose model
module tb_matrix_transpose_afu;
  localparam int N = 16;
  localparam int DW = 32;
  logic clk = 0;
  logic reset = 0;
  logic [511:0] input_fifo_din = '0;
  logic input_fifo_we = 0;
  logic input_fifo_full, input_fifo_almost_full;
  logic [3:0] input_fifo_count;
  logic [511:0] output_fifo_dout;
  logic output_fifo_re = 0;
  logic output_fifo_empty, output_fifo_almost_empty;
  logic [31:0] ctx_length = 0;
  int checks = 0;
  int errors = 0;
  bit auto_re = 0;
  logic [511:0] src[$];
  logic [511:0] got[$];
  logic [511:0] exp_q[$];
  logic [511:0] rows[$];

  typedef struct {int tid; int line; int word; logic [31:0] val;} vec_t;
  vec_t tbl[10];

  matrix_transpose_afu dut (
    .clk(clk), .reset(reset),
    .input_fifo_din(input_fifo_din), .input_fifo_we(input_fifo_we),
    .input_fifo_full(input_fifo_full), .input_fifo_almost_full(input_fifo_almost_full),
    .input_fifo_count(input_fifo_count),
    .output_fifo_dout(output_fifo_dout), .output_fifo_re(output_fifo_re),
    .output_fifo_empty(output_fifo_empty), .output_fifo_almost_empty(output_fifo_almost_empty),
    .ctx_length(ctx_length)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, want);
    end
  endtask

  task automatic tick();
    logic rd;
    rd = output_fifo_re && !output_fifo_empty;
    if (input_fifo_we && !input_fifo_full) src.push_back(input_fifo_din);
    @(posedge clk);
    #1;
    if (rd) got.push_back(output_fifo_dout);
  endtask

  task automatic step();
    output_fifo_re = auto_re && !output_fifo_empty;
    tick();
  endtask

  task automatic do_reset();
    reset = 0;
    input_fifo_we = 0;
    output_fifo_re = 0;
    auto_re = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1;
    src.delete();
    got.delete();
  endtask

  task automatic feed(input int gap_pct);
    int idx = 0;
    int k = 0;
    bit acc;
    while (idx < rows.size() && k < 3000) begin
      input_fifo_we = $urandom_range(99) >= gap_pct;
      input_fifo_din = rows[idx];
      acc = input_fifo_we && !input_fifo_full;
      step();
      if (acc) idx++;
      k++;
    end
    input_fifo_we = 0;
    if (idx < rows.size()) chk("feed_timeout", 512'(idx), 512'(rows.size()));
  endtask

  task automatic wait_lines(input int n);
    int k = 0;
    while (got.size() < n && k < 2000) begin
      step();
      k++;
    end
    repeat (40) step();
  endtask

  // transpose every block of accepted rows; a partial final block is padded with zero rows
  task automatic build_exp(input int ctx);
    int lim, nb, idx;
    logic [511:0] line, row;
    exp_q.delete();
    lim = ctx == 0 ? (src.size() / N) * N : (src.size() < ctx ? src.size() : ctx);
    nb = (lim + N - 1) / N;
    for (int b = 0; b < nb; b++)
      for (int c = 0; c < N; c++) begin
        line = '0;
        for (int r = 0; r < N; r++) begin
          idx = b * N + r;
          row = idx < lim ? src[idx] : '0;
          line[r*DW +: DW] = row[c*DW +: DW];
        end
        exp_q.push_back(line);
      end
  endtask

  task automatic check_lines(input string nm, input int ctx);
    build_exp(ctx);
    chk({nm, "_nlines"}, 512'(got.size()), 512'(exp_q.size()));
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_line%0d", nm, i), got[i], exp_q[i]);
  endtask

  task automatic check_table(input int tid);
    logic [511:0] l;
    for (int i = 0; i < 10; i++)
      if (tbl[i].tid == tid) begin
        l = tbl[i].line < got.size() ? got[tbl[i].line] : '0;
        chk($sformatf("tbl%0d_l%0d_w%0d", tid, tbl[i].line, tbl[i].word),
            512'(l[tbl[i].word*DW +: DW]), 512'(tbl[i].val));
      end
  endtask

  task automatic check_idle(input string nm);
    chk({nm, "_out_empty"}, 512'(output_fifo_empty), 512'(1));
    chk({nm, "_out_aempty"}, 512'(output_fifo_almost_empty), 512'(1));
    chk({nm, "_dout"}, output_fifo_dout, '0);
    chk({nm, "_in_count"}, 512'(input_fifo_count), '0);
    chk({nm, "_in_full"}, 512'(input_fifo_full), '0);
    chk({nm, "_in_afull"}, 512'(input_fifo_almost_full), '0);
  endtask

  task automatic rand_rows(input int n, output logic [511:0] q[$]);
    logic [511:0] v;
    q.delete();
    for (int i = 0; i < n; i++) begin
      for (int w = 0; w < N; w++) v[w*DW +: DW] = $urandom;
      q.push_back(v);
    end
  endtask

  initial begin
    logic [511:0] v;
    int k;
    tbl[0] = '{1, 0, 1, 32'h10};
    tbl[1] = '{1, 15, 15, 32'hFF};
    tbl[2] = '{1, 0, 0, 32'h0};
    tbl[3] = '{1, 3, 2, 32'h23};
    tbl[4] = '{1, 7, 9, 32'h97};
    tbl[5] = '{1, 15, 0, 32'h0F};
    tbl[6] = '{2, 0, 4, 32'hA5A5A5A5};
    tbl[7] = '{2, 0, 5, 32'h0};
    tbl[8] = '{2, 9, 0, 32'hA5A5A5A5};
    tbl[9] = '{2, 15, 15, 32'h0};

    do_reset();
    check_idle("reset");

    // single patterned block
    ctx_length = 16;
    rows.delete();
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) v[c*DW +: DW] = 32'(r * 16 + c);
      rows.push_back(v);
    end
    auto_re = 1;
    feed(0);
    wait_lines(16);
    check_lines("single", 16);
    check_table(1);

    // four random blocks with write gaps
    do_reset();
    ctx_length = 64;
    rand_rows(64, rows);
    auto_re = 1;
    feed(40);
    wait_lines(64);
    check_lines("gaps", 64);

    // partial flush
    do_reset();
    ctx_length = 5;
    rows.delete();
    for (int i = 0; i < 5; i++) rows.push_back({16{32'hA5A5A5A5}});
    auto_re = 1;
    feed(0);
    wait_lines(16);
    check_lines("flush", 5);
    check_table(2);

    // output stall, then input overflow while the core sits in DRAIN
    do_reset();
    ctx_length = 0;
    rand_rows(16, rows);
    feed(0);
    k = 0;
    while (!output_fifo_empty === 1'b0 || k < 1) begin
      k++;
      if (k > 1) break;
    end
    k = 0;
    while (!input_fifo_full && k < 60) begin
      step();
      k++;
      if (k > 40) break;
    end
    chk("stall_out_not_empty", 512'(output_fifo_empty), '0);
    chk("stall_no_reads", 512'(got.size()), '0);
    for (int i = 0; i < 9; i++) begin
      for (int w = 0; w < N; w++) v[w*DW +: DW] = $urandom;
      input_fifo_we = 1;
      input_fifo_din = v;
      step();
    end
    input_fifo_we = 0;
    chk("ovf_src_accepted", 512'(src.size()), 512'(24));
    chk("ovf_count", 512'(input_fifo_count), 512'(8));
    chk("ovf_full", 512'(input_fifo_full), 512'(1));
    chk("ovf_afull", 512'(input_fifo_almost_full), 512'(1));
    auto_re = 1;
    wait_lines(16);
    check_lines("stall", 0);

    // reset in the middle of draining
    do_reset();
    ctx_length = 16;
    rand_rows(16, rows);
    auto_re = 1;
    feed(0);
    k = 0;
    while (got.size() < 3 && k < 200) begin
      step();
      k++;
    end
    chk("mid_reads", 512'(got.size()), 512'(3));
    output_fifo_re = 0;
    auto_re = 0;
    reset = 0;
    #1;
    check_idle("midreset");
    @(negedge clk);
    reset = 1;
    src.delete();
    got.delete();
    rand_rows(16, rows);
    auto_re = 1;
    feed(20);
    wait_lines(16);
    check_lines("after_reset", 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
